// File: rtl/msff_pkg.sv
// Shared definitions for the msff shift array.
// Mode encodings and the Count width helper.
package msff_pkg;

  localparam logic [1:0] MODE_HOLD  = 2'b00;
  localparam logic [1:0] MODE_SHIFT = 2'b01;
  localparam logic [1:0] MODE_LOAD  = 2'b10;
  localparam logic [1:0] MODE_ROT   = 2'b11;

  function automatic int msff_cw(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/msff_reg.sv
// WIDTH-bit rising-edge register with
// asynchronous active-low clear.
module msff_reg #(
  parameter int WIDTH = 4
) (
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] Q
);

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) Q <= '0;
    else        Q <= D;
  end

endmodule

// File: rtl/msff_shift_array.sv
// DEPTH x WIDTH register array: hold/shift/load/rotate with fill count.
// Optional scan chain enabled by defining MSFF_SCAN_EN.
module msff_shift_array
  import msff_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4,
  parameter int CW    = msff_cw(DEPTH)
) (
  input  logic                   Clk,
  input  logic                   Rst_n,
  input  logic [1:0]             Mode,
  input  logic [WIDTH-1:0]       Din,
  input  logic [WIDTH*DEPTH-1:0] Load_data,
`ifdef MSFF_SCAN_EN
  input  logic                   Scan_en,
  input  logic                   Scan_in,
  output logic                   Scan_out,
`endif
  output logic [WIDTH-1:0]       Dout,
  output logic [WIDTH*DEPTH-1:0] Q_all,
  output logic [CW-1:0]          Count,
  output logic                   Full
);

  localparam int NB = WIDTH * DEPTH;
  localparam logic [CW-1:0] CMAX = CW'(DEPTH);

  logic [WIDTH-1:0] q [DEPTH];
  logic [WIDTH-1:0] d [DEPTH];
  logic [CW-1:0]    cnt;
  logic [CW-1:0]    cnt_d;

  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    msff_reg #(.WIDTH(WIDTH)) u_reg (
      .Clk  (Clk),
      .Rst_n(Rst_n),
      .D    (d[i]),
      .Q    (q[i])
    );
    assign Q_all[i*WIDTH +: WIDTH] = q[i];
  end

`ifdef MSFF_SCAN_EN
  logic [NB-1:0] scan_nx;
  assign scan_nx  = {Q_all[NB-2:0], Scan_in};
  assign Scan_out = Q_all[NB-1];
`endif

  always_comb begin
    for (int i = 0; i < DEPTH; i++) d[i] = q[i];
    cnt_d = cnt;
    unique case (1'b1)
      (Mode == MODE_HOLD): ;
      (Mode == MODE_SHIFT): begin
        d[0] = Din;
        for (int i = 1; i < DEPTH; i++) d[i] = q[i-1];
        if (cnt != CMAX) cnt_d = cnt + 1'b1;
      end
      (Mode == MODE_LOAD): begin
        for (int i = 0; i < DEPTH; i++)
          d[i] = Load_data[i*WIDTH +: WIDTH];
        cnt_d = CMAX;
      end
      (Mode == MODE_ROT): begin
        d[0] = q[DEPTH-1];
        for (int i = 1; i < DEPTH; i++) d[i] = q[i-1];
      end
      default: ;
    endcase
`ifdef MSFF_SCAN_EN
    // Scan overrides Mode and leaves the fill level alone
    if (Scan_en) begin
      for (int i = 0; i < DEPTH; i++)
        d[i] = scan_nx[i*WIDTH +: WIDTH];
      cnt_d = cnt;
    end
`endif
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) cnt <= '0;
    else        cnt <= cnt_d;
  end

  assign Count = cnt;
  assign Full  = (cnt == CMAX);
  assign Dout  = q[DEPTH-1];

endmodule

// File: tb/tb_msff_shift_array.sv
// Self-checking bench for msff_shift_array (WIDTH=4, DEPTH=4).
// Define MSFF_SCAN_EN to also exercise the scan chain.
module tb_msff_shift_array;

  logic        clk = 0;
  logic        rst_n;
  logic [1:0]  mode;
  logic [3:0]  din;
  logic [15:0] ld;
  logic [3:0]  dout;
  logic [15:0] q_all;
  logic [2:0]  count;
  logic        full;
`ifdef MSFF_SCAN_EN
  logic scan_en, scan_in, scan_out;
`endif

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [1:0]  mode;
    logic [3:0]  din;
    logic [15:0] ld;
    logic [15:0] q;
    logic [2:0]  cnt;
  } vec_t;

  vec_t sb[$];
  vec_t vt[10];

  always #5 clk = ~clk;

  msff_shift_array #(.WIDTH(4), .DEPTH(4)) dut (
    .Clk      (clk),
    .Rst_n    (rst_n),
    .Mode     (mode),
    .Din      (din),
    .Load_data(ld),
`ifdef MSFF_SCAN_EN
    .Scan_en  (scan_en),
    .Scan_in  (scan_in),
    .Scan_out (scan_out),
`endif
    .Dout     (dout),
    .Q_all    (q_all),
    .Count    (count),
    .Full     (full)
  );

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag,
                           input logic [15:0] eq,
                           input logic [2:0] ec);
    check({tag, ".q"},    32'(q_all), 32'(eq));
    check({tag, ".cnt"},  32'(count), 32'(ec));
    check({tag, ".full"}, 32'(full),  32'(ec == 3'd4));
    check({tag, ".dout"}, 32'(dout),  32'(eq[15:12]));
  endtask

  task automatic step(input vec_t v, input string tag);
    vec_t e;
    mode = v.mode;
    din  = v.din;
    ld   = v.ld;
    sb.push_back(v);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      total++;
      bad++;
      $display("FAIL %s: scoreboard empty", tag);
    end else begin
      e = sb.pop_front();
      check_all(tag, e.q, e.cnt);
    end
  endtask

  function automatic vec_t mk(input logic [1:0] m,
                              input logic [3:0] dn,
                              input logic [15:0] l,
                              input logic [15:0] q,
                              input logic [2:0] c);
    vec_t v;
    v.mode = m; v.din = dn; v.ld = l; v.q = q; v.cnt = c;
    return v;
  endfunction

  initial begin
    vec_t v;
    logic [15:0] pat;
    logic [15:0] snap_q;
    logic [2:0]  snap_c;

    vt[0] = mk(2'b01, 4'h1, 16'h0, 16'h0001, 3'd1);
    vt[1] = mk(2'b01, 4'h2, 16'h0, 16'h0012, 3'd2);
    vt[2] = mk(2'b01, 4'h3, 16'h0, 16'h0123, 3'd3);
    vt[3] = mk(2'b01, 4'h4, 16'h0, 16'h1234, 3'd4);
    vt[4] = mk(2'b01, 4'h5, 16'h0, 16'h2345, 3'd4);
    vt[5] = mk(2'b10, 4'h0, 16'h4321, 16'h4321, 3'd4);
    vt[6] = mk(2'b11, 4'h0, 16'hFFFF, 16'h3214, 3'd4);
    vt[7] = mk(2'b11, 4'h0, 16'h0, 16'h2143, 3'd4);
    vt[8] = mk(2'b11, 4'h0, 16'h0, 16'h1432, 3'd4);
    vt[9] = mk(2'b11, 4'h0, 16'h0, 16'h4321, 3'd4);

    rst_n = 0; mode = 2'b01; din = 4'hF; ld = 16'hFFFF;
`ifdef MSFF_SCAN_EN
    scan_en = 0; scan_in = 0;
`endif
    repeat (2) @(posedge clk);
    #1;
    check_all("reset", 16'h0, 3'd0);

    @(negedge clk);
    rst_n = 1;
    mode  = 2'b00;
    step(mk(2'b10, 4'h0, 16'hDCBA, 16'hDCBA, 3'd4), "preload");

    // asynchronous clear mid-cycle, no edge in between
    @(negedge clk);
    mode  = 2'b00;
    rst_n = 0;
    #1;
    check_all("async_rst", 16'h0, 3'd0);
    #1;
    rst_n = 1;

    for (int i = 0; i < 10; i++)
      step(vt[i], $sformatf("vec%0d", i));

    for (int i = 0; i < 10; i++)
      step(mk(2'b00, 4'(i), 16'(i * 16'h1111), 16'h4321, 3'd4),
           $sformatf("hold%0d", i));

    // reset held across a load edge: load must be lost
    mode  = 2'b10;
    ld    = 16'hFFFF;
    rst_n = 0;
    @(posedge clk);
    #1;
    check_all("rst_load", 16'h0, 3'd0);
    @(negedge clk);
    rst_n = 1;

    step(mk(2'b01, 4'h7, 16'h0, 16'h0007, 3'd1), "rel_shift");
    step(mk(2'b11, 4'h0, 16'h0, 16'h0070, 3'd1), "rot_part1");
    step(mk(2'b11, 4'h0, 16'h0, 16'h0700, 3'd1), "rot_part2");
    step(mk(2'b11, 4'h0, 16'h0, 16'h7000, 3'd1), "rot_part3");
    step(mk(2'b11, 4'h0, 16'h0, 16'h0007, 3'd1), "rot_part4");
    step(mk(2'b01, 4'h9, 16'h0, 16'h0079, 3'd2), "shift_mid");

`ifdef MSFF_SCAN_EN
    snap_q = 16'h0079;
    snap_c = 3'd2;
    pat = 16'hBEEF;
    mode = 2'b10;
    ld = 16'h1111;
    scan_en = 1;
    // MSB first, so the first bit lands at stage3 bit3
    for (int i = 15; i >= 0; i--) begin
      scan_in = pat[i];
      @(posedge clk);
      #1;
    end
    check("scan_load.q", 32'(q_all), 32'(pat));
    check("scan_load.cnt", 32'(count), 32'(snap_c));
    for (int i = 15; i >= 0; i--) begin
      check($sformatf("scan_out%0d", i), 32'(scan_out), 32'(pat[i]));
      scan_in = 0;
      @(posedge clk);
      #1;
    end
    check("scan_drain.q", 32'(q_all), 32'h0);
    check("scan_drain.cnt", 32'(count), 32'(snap_c));
    scan_en = 0;
    step(mk(2'b00, 4'h0, 16'h0, 16'h0000, 3'd2), "post_scan");
`else
    snap_q = 16'h0;
    snap_c = 3'd0;
    pat = 16'h0;
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
